// File: rtl/conv_bcd_saida_pkg.sv
// Shared definitions for the OUT-path BCD output stage.
//   estado_t  : converter state encoding (IDLE/SHIFT/COMMIT)
//   CONV_BITS : bits shifted per conversion (2^14 > 9999)
//   MAX_DISP  : largest displayable magnitude before saturation
//   NIB_W     : BCD nibble width, NUM_DIG : digits on the display
package pkg_saida;
  localparam int CONV_BITS = 14;
  localparam int MAX_DISP  = 9999;
  localparam int NIB_W     = 4;
  localparam int NUM_DIG   = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} estado_t;
endpackage

// File: rtl/conv_bcd_saida_if.sv
// Bus between the control unit / register file and the BCD output stage.
//   master : drives out_en strobe and valor, reads digits and flags
//   slave  : the converter; reads out_en/valor, drives mil/cent/dez/uni,
//            neg, ovf, busy, valid
interface conv_bcd_saida_if #(parameter int WIDTH = 32);
  logic             out_en;
  logic [WIDTH-1:0] valor;
  logic [3:0]       mil;
  logic [3:0]       cent;
  logic [3:0]       dez;
  logic [3:0]       uni;
  logic             neg;
  logic             ovf;
  logic             busy;
  logic             valid;

  modport master (output out_en, valor,
                  input  mil, cent, dez, uni, neg, ovf, busy, valid);
  modport slave  (input  out_en, valor,
                  output mil, cent, dez, uni, neg, ovf, busy, valid);
endinterface

// File: rtl/conv_bcd_saida_ajuste3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
//   din  : BCD nibble before the shift
//   dout : corrected nibble
module bcd_ajuste3
  import pkg_saida::*;
(
  input  logic [NIB_W-1:0] din,
  output logic [NIB_W-1:0] dout
);
  assign dout = (din >= NIB_W'(5)) ? din + NIB_W'(3) : din;
endmodule

// File: rtl/conv_bcd_saida.sv
// OUT-path output stage: captures valor on out_en, converts |valor| to four
// BCD digits with a one-bit-per-clock double-dabble, and holds the digits
// and sign/overflow flags for the 7-segment decoders. A one-entry pending
// register absorbs strobes that arrive while a conversion is running.
//   clk, reset_n : CPU clock, async active-low reset
//   io (slave)   : out_en/valor in; mil/cent/dez/uni, neg, ovf, busy, valid out
module conv_bcd_saida
  import pkg_saida::*;
#(
  parameter int WIDTH     = 32,
  parameter int CONV_BITS = pkg_saida::CONV_BITS,
  parameter int MAX_DISP  = pkg_saida::MAX_DISP
) (
  input  logic              clk,
  input  logic              reset_n,
  conv_bcd_saida_if.slave   io
);
  localparam int CNT_W = $clog2(CONV_BITS + 1);
  localparam int ACC_W = NUM_DIG * NIB_W;

  estado_t              estado;
  logic [CNT_W-1:0]     cnt;
  logic [CONV_BITS-1:0] sr;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     accAdj;
  logic                 signR;
  logic                 satR;
  logic [WIDTH-1:0]     pendVal;
  logic                 pendV;

  // Value about to be loaded into the converter: the pending entry wins in
  // COMMIT, otherwise the live bus value. Pending is only ever set while
  // busy, so IDLE always loads the live value.
  logic [WIDTH-1:0] srcVal;
  logic [WIDTH-1:0] magSrc;
  logic             satSrc;

  assign srcVal = (estado == COMMIT && pendV) ? pendVal : io.valor;
  // Unsigned negate: the most negative value maps to 2^(WIDTH-1).
  assign magSrc = srcVal[WIDTH-1] ? (~srcVal + WIDTH'(1)) : srcVal;
  assign satSrc = magSrc > WIDTH'(MAX_DISP);

  for (genvar g = 0; g < NUM_DIG; g++) begin : gDig
    bcd_ajuste3 uAj (
      .din  (acc[g*NIB_W +: NIB_W]),
      .dout (accAdj[g*NIB_W +: NIB_W])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      acc      <= '0;
      signR    <= 1'b0;
      satR     <= 1'b0;
      pendVal  <= '0;
      pendV    <= 1'b0;
      io.mil   <= '0;
      io.cent  <= '0;
      io.dez   <= '0;
      io.uni   <= '0;
      io.neg   <= 1'b0;
      io.ovf   <= 1'b0;
      io.busy  <= 1'b0;
      io.valid <= 1'b0;
    end else begin
      io.valid <= 1'b0;
      case (estado)
        IDLE: begin
          if (io.out_en) begin
            sr      <= magSrc[CONV_BITS-1:0];
            acc     <= '0;
            signR   <= srcVal[WIDTH-1];
            satR    <= satSrc;
            cnt     <= '0;
            io.busy <= 1'b1;
            estado  <= SHIFT;
          end
        end

        SHIFT: begin
          // Correct every digit, then shift {acc,sr} left by one.
          acc <= {accAdj[ACC_W-2:0], sr[CONV_BITS-1]};
          sr  <= {sr[CONV_BITS-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CONV_BITS - 1)) estado <= COMMIT;
          // Last strobe wins; the running conversion is never disturbed.
          if (io.out_en) begin
            pendVal <= io.valor;
            pendV   <= 1'b1;
          end
        end

        COMMIT: begin
          if (satR) begin
            io.mil  <= 4'd9;
            io.cent <= 4'd9;
            io.dez  <= 4'd9;
            io.uni  <= 4'd9;
          end else begin
            io.mil  <= acc[15:12];
            io.cent <= acc[11:8];
            io.dez  <= acc[7:4];
            io.uni  <= acc[3:0];
          end
          io.neg   <= signR;
          io.ovf   <= satR;
          io.valid <= 1'b1;

          if (pendV || io.out_en) begin
            // Restart immediately from pending (or a strobe landing right
            // now) so back-to-back OUTs see no idle gap.
            sr     <= magSrc[CONV_BITS-1:0];
            acc    <= '0;
            signR  <= srcVal[WIDTH-1];
            satR   <= satSrc;
            cnt    <= '0;
            estado <= SHIFT;
            if (pendV && io.out_en) begin
              pendVal <= io.valor;
              pendV   <= 1'b1;
            end else begin
              pendV   <= 1'b0;
            end
          end else begin
            io.busy <= 1'b0;
            estado  <= IDLE;
          end
        end

        default: estado <= IDLE;
      endcase
    end
  end
endmodule
